// File: rtl/rf_alu_seq.sv
// rf_alu_seq: instruction sequencer for the register-file/ALU datapath.
// Each accepted 32-bit word runs for one EXEC cycle and, for ALU and LDI,
// one WB cycle. The sequencer drives the datapath control lanes, registers
// the ALU zero/overflow results and counts retired instructions.
//
// state | meaning
// IDLE  | ready for a new word; in_ready = 1
// EXEC  | read ports and aluc driven; flags latched for ALU/CMP
// WB    | we = 1; s selects ALU result (ALU) or immediate (LDI)
module rf_alu_seq #(
    parameter int IMM_SEXT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic [4:0]       ra,
    output logic [4:0]       rb,
    output logic [4:0]       rw,
    output logic             we,
    output logic             s,
    output logic [1:0]       aluc,
    output logic [31:0]      rd,
    input  logic             z,
    input  logic             v,
    output logic             z_flag,
    output logic             v_flag,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_instr;
    logic               r_z_flag;
    logic               r_v_flag;
    logic               r_done;
    logic [CNT_W-1:0]   r_retired;

    logic               w_accept;
    logic               w_retire;
    logic               w_flag_upd;
    logic [1:0]         w_op;
    logic               w_is_alu_fmt;
    logic [15:0]        w_imm;
    logic [31:0]        w_imm_ext;

    assign w_op         = r_instr[31:30];
    assign w_is_alu_fmt = (w_op == OP_ALU) || (w_op == OP_CMP);
    assign w_imm        = r_instr[15:0];
    assign w_accept     = in_valid && in_ready;

    // Immediate extension selected at elaboration time.
    always_comb begin
        w_imm_ext = {16'h0000, w_imm};
        if (IMM_SEXT != 0) begin
            w_imm_ext = {{16{w_imm[15]}}, w_imm};
        end
    end

    // Next-state, retire and flag-capture decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_flag_upd  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_flag_upd = w_is_alu_fmt;
                if ((w_op == OP_ALU) || (w_op == OP_LDI)) begin
                    w_state_nxt = ST_WB;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_retire    = 1'b1;
                end
            end
            ST_WB: begin
                w_state_nxt = ST_IDLE;
                w_retire    = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath control lanes decoded from the latched word only.
    always_comb begin
        in_ready = (r_state == ST_IDLE);
        we       = (r_state == ST_WB);
        s        = (r_state == ST_WB) && (w_op == OP_LDI);
        ra       = 5'd0;
        rb       = 5'd0;
        aluc     = 2'd0;
        rw       = 5'd0;
        rd       = w_imm_ext;
        if (w_is_alu_fmt) begin
            aluc = r_instr[29:28];
            ra   = r_instr[22:18];
            rb   = r_instr[17:13];
        end
        if (w_op == OP_ALU) begin
            rw = r_instr[27:23];
        end else if (w_op == OP_LDI) begin
            rw = r_instr[20:16];
        end
    end

    // State register; reset wins over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction latch; the word is held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= 32'h0000_0000;
        end else if (w_accept) begin
            r_instr <= in_instr;
        end
    end

    // Zero/overflow flags sampled at the end of EXEC for ALU and CMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z_flag <= 1'b0;
            r_v_flag <= 1'b0;
        end else if (w_flag_upd) begin
            r_z_flag <= z;
            r_v_flag <= v;
        end
    end

    // Retire pulse and wrapping retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_done <= w_retire;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign z_flag  = r_z_flag;
    assign v_flag  = r_v_flag;
    assign done    = r_done;
    assign retired = r_retired;

endmodule

// File: tb/tb_rf_alu_seq.sv
// Bench for rf_alu_seq: two instances share stimulus; dut_a uses a
// sign-extended immediate and 16-bit counter, dut_b zero-extends with a
// 2-bit counter so wrap-around is reachable.
module tb_rf_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        z;
    logic        v;

    logic        in_ready_a, we_a, s_a, z_flag_a, v_flag_a, done_a;
    logic [4:0]  ra_a, rb_a, rw_a;
    logic [1:0]  aluc_a;
    logic [31:0] rd_a;
    logic [15:0] retired_a;

    logic        in_ready_b, we_b, s_b, z_flag_b, v_flag_b, done_b;
    logic [4:0]  ra_b, rb_b, rw_b;
    logic [1:0]  aluc_b;
    logic [31:0] rd_b;
    logic [1:0]  retired_b;

    rf_alu_seq #(.IMM_SEXT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .ra(ra_a), .rb(rb_a), .rw(rw_a), .we(we_a),
        .s(s_a), .aluc(aluc_a), .rd(rd_a), .z(z), .v(v),
        .z_flag(z_flag_a), .v_flag(v_flag_a), .done(done_a), .retired(retired_a)
    );

    rf_alu_seq #(.IMM_SEXT(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .ra(ra_b), .rb(rb_b), .rw(rw_b), .we(we_b),
        .s(s_b), .aluc(aluc_b), .rd(rd_b), .z(z), .v(v),
        .z_flag(z_flag_b), .v_flag(v_flag_b), .done(done_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        logic        zi;
        logic        vi;
        bit          hold;
        int          lat;
        bit          ldi;
        bit          rab;
        logic [4:0]  rw_e;
        logic [4:0]  ra_e;
        logic [4:0]  rb_e;
        logic [1:0]  aluc_e;
        logic [31:0] rd_s;
        logic [31:0] rd_z;
        logic        zf;
        logic        vf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cnt_model = 0;
    logic m_zf = 1'b0;
    logic m_vf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-format rules.
    function automatic vec_t model(input logic [31:0] w, input logic zi, input logic vi, input bit hold);
        vec_t t;
        logic [15:0] imm;
        imm = w[15:0];
        t.word = w; t.zi = zi; t.vi = vi; t.hold = hold;
        t.lat = 2; t.ldi = 0; t.rab = 0;
        t.rw_e = 0; t.ra_e = 0; t.rb_e = 0; t.aluc_e = 0;
        t.rd_s = 0; t.rd_z = 0; t.zf = m_zf; t.vf = m_vf;
        case (w[31:30])
            2'b00: begin
                t.lat = 3; t.rab = 1; t.rw_e = w[27:23];
                t.ra_e = w[22:18]; t.rb_e = w[17:13]; t.aluc_e = w[29:28];
                t.zf = zi; t.vf = vi;
            end
            2'b01: begin
                t.lat = 3; t.ldi = 1; t.rw_e = w[20:16];
                t.rd_s = 32'(signed'(imm));
                t.rd_z = {16'h0000, imm};
            end
            2'b10: begin
                t.rab = 1; t.ra_e = w[22:18]; t.rb_e = w[17:13]; t.aluc_e = w[29:28];
                t.zf = zi; t.vf = vi;
            end
            default: ;
        endcase
        return t;
    endfunction

    // Runs one instruction from an IDLE negedge to the negedge after retire.
    task automatic issue(input vec_t t, output int acc_cyc);
        in_instr = t.word;
        in_valid = 1'b1;
        chk("ready_idle", in_ready_a, 1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (!t.hold) in_valid = 1'b0;
        z = t.zi;
        v = t.vi;
        chk("exec_ready", in_ready_a, 0);
        chk("exec_we", we_a, 0);
        chk("exec_s", s_a, 0);
        chk("exec_done", done_a, 0);
        if (t.rab) begin
            chk("exec_ra", ra_a, t.ra_e);
            chk("exec_rb", rb_a, t.rb_e);
            chk("exec_aluc", aluc_a, t.aluc_e);
        end
        @(posedge clk);
        @(negedge clk);
        if (t.lat == 3) begin
            z = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            chk("wb_we", we_a, 1);
            chk("wb_s", s_a, t.ldi);
            chk("wb_rw", rw_a, t.rw_e);
            chk("wb_ready", in_ready_a, 0);
            chk("wb_done", done_a, 0);
            chk("wb_zflag", z_flag_a, t.zf);
            chk("wb_vflag", v_flag_a, t.vf);
            if (t.ldi) begin
                chk("wb_rd_sext", rd_a, t.rd_s);
                chk("wb_rd_zext", rd_b, t.rd_z);
            end
            if (t.rab) begin
                chk("wb_ra", ra_a, t.ra_e);
                chk("wb_rb", rb_a, t.rb_e);
                chk("wb_aluc", aluc_a, t.aluc_e);
            end
            @(posedge clk);
            @(negedge clk);
        end
        cnt_model++;
        m_zf = t.zf;
        m_vf = t.vf;
        chk("ret_done_a", done_a, 1);
        chk("ret_done_b", done_b, 1);
        chk("ret_ready", in_ready_a, 1);
        chk("ret_we", we_a, 0);
        chk("ret_s", s_a, 0);
        chk("ret_zflag", z_flag_a, t.zf);
        chk("ret_vflag", v_flag_a, t.vf);
        chk("ret_cnt_a", retired_a, 32'(cnt_model % 65536));
        chk("ret_cnt_b", retired_b, 32'(cnt_model % 4));
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_ready", in_ready_a, 1);
        chk("idle_done", done_a, 0);
        chk("idle_we", we_a, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt_model = 0;
        m_zf = 1'b0;
        m_vf = 1'b0;
    endtask

    vec_t tbl[9];
    int   acc[9];
    int   a0;
    int   exp_seq[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // word, zi, vi, hold, lat, ldi, rab, rw, ra, rb, aluc, rd_sext, rd_zext, z_flag, v_flag
        tbl[0] = '{32'h4003FFFF, 0, 0, 0, 3, 1, 0, 3, 0, 0, 0, 32'hFFFFFFFF, 32'h0000FFFF, 0, 0};
        tbl[1] = '{32'h12044000, 1, 0, 0, 3, 0, 1, 4, 1, 2, 1, 0, 0, 1, 0};
        tbl[2] = '{32'hA394C000, 0, 1, 0, 2, 0, 1, 0, 5, 6, 2, 0, 0, 0, 1};
        tbl[3] = '{32'hC0000000, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[4] = '{32'h3FFFE000, 0, 1, 1, 3, 0, 1, 31, 31, 31, 3, 0, 0, 0, 1};
        tbl[5] = '{32'h00000000, 1, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[6] = '{32'h248C8000, 0, 0, 1, 3, 0, 1, 9, 3, 4, 2, 0, 0, 0, 0};
        tbl[7] = '{32'h401F7FFF, 0, 1, 0, 3, 1, 0, 31, 0, 0, 0, 32'h00007FFF, 32'h00007FFF, 0, 0};
        tbl[8] = '{32'h40008000, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 32'hFFFF8000, 32'h00008000, 0, 0};
        exp_seq = '{1, 2, 3, 0, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'h0;
        z = 1'b0;
        v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready_a, 1);
        chk("rst_we", we_a, 0);
        chk("rst_s", s_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_zflag", z_flag_a, 0);
        chk("rst_vflag", v_flag_a, 0);
        chk("rst_ctrl", {ra_a, rb_a, rw_a, aluc_a}, 0);
        chk("rst_rd", rd_a, 0);
        chk("rst_cnt", retired_a, 0);
        rst = 1'b0;

        // Directed table, issued back to back.
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i], acc[i]);
            if (i > 0) chk("accept_gap", 32'(acc[i] - acc[i-1]), 32'(tbl[i-1].lat));
        end
        in_valid = 1'b0;
        idle_cycle();

        // Reset during WB of an ALU word that sets both flags.
        in_instr = 32'h12044000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        z = 1'b1;
        v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_we", we_a, 1);
        chk("pre_rst_flags", {z_flag_a, v_flag_a}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("wbrst_we", we_a, 0);
        chk("wbrst_ready", in_ready_a, 1);
        chk("wbrst_cnt", retired_a, 0);
        chk("wbrst_flags", {z_flag_a, v_flag_a}, 0);
        chk("wbrst_done", done_a, 0);
        cnt_model = 0;
        m_zf = 1'b0;
        m_vf = 1'b0;

        // Reset beats a same-cycle accept.
        in_instr = 32'h3FFFE000;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rstacc_ready", in_ready_a, 1);
        chk("rstacc_ra", ra_a, 0);
        idle_cycle();

        // Counter wrap on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            issue(model(32'hC0000000, 1'b0, 1'b0, 1'b0), a0);
            chk("wrap_seq", retired_b, 32'(exp_seq[i]));
        end
        in_valid = 1'b0;

        // Randomized instructions with idle gaps and held valids.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            issue(model($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        bit'($urandom_range(0, 1))), a0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        in_valid = 1'b0;
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
